// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Optional macro DIV_SIGNED_EN adds an is_signed input for two's-complement operation.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic             sgn_c;
  logic             a_neg_c, b_neg_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [WIDTH:0]   shift_c;
  logic [WIDTH+1:0] sum_c;
  logic             carry_c;
  logic [WIDTH:0]   r_nxt_c;
  logic [WIDTH-1:0] q_nxt_c;

`ifdef DIV_SIGNED_EN
  assign sgn_c = is_signed;
`else
  assign sgn_c = 1'b0;
`endif

  // Operand magnitudes; signs are remembered to fix up the result at the end.
  assign a_neg_c = sgn_c & dividend[WIDTH-1];
  assign b_neg_c = sgn_c & divisor[WIDTH-1];
  assign a_mag_c = a_neg_c ? WIDTH'(~dividend + WIDTH'(1)) : dividend;
  assign b_mag_c = b_neg_c ? WIDTH'(~divisor + WIDTH'(1)) : divisor;

  // Trial subtraction R + ~D + 1; the carry-out means no borrow.
  assign shift_c = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign sum_c   = {1'b0, shift_c} + {1'b0, ~{1'b0, d_q}} + (WIDTH+2)'(1);
  assign carry_c = sum_c[WIDTH+1];
  assign r_nxt_c = carry_c ? sum_c[WIDTH:0] : shift_c;
  assign q_nxt_c = {q_q[WIDTH-2:0], carry_c};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dbz_d  = 1'b0;
          ovf_d  = sgn_c && (dividend == MIN_NEG) && (divisor == '1);
          cnt_d  = '0;
          r_d    = '0;
          d_d    = b_mag_c;
          qneg_d = a_neg_c ^ b_neg_c;
          rneg_d = a_neg_c;
          busy_d = 1'b1;
          if (divisor == '0) begin
            // Raw dividend is kept so it can be returned as the remainder.
            state_d = DONE;
            q_d     = dividend;
          end else begin
            state_d = RUN;
            q_d     = a_mag_c;
          end
        end
      end

      RUN: begin
        busy_d = 1'b1;
        r_d    = r_nxt_c;
        q_d    = q_nxt_c;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = qneg_q ? WIDTH'(~q_nxt_c + WIDTH'(1)) : q_nxt_c;
          rem_d   = rneg_q ? WIDTH'(~r_nxt_c[WIDTH-1:0] + WIDTH'(1))
                           : r_nxt_c[WIDTH-1:0];
        end
      end

      DONE: begin
        state_d = IDLE;
        // Entering DONE straight from IDLE means divide-by-zero: publish now.
        if (!done_q) begin
          done_d = 1'b1;
          quo_d  = '1;
          rem_d  = q_q;
          dbz_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed, table-driven bench for seq_divider (signed vectors when DIV_SIGNED_EN is defined).
module tb_seq_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
`ifdef DIV_SIGNED_EN
  logic       is_signed;
`endif
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  seq_divider #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef DIV_SIGNED_EN
    .is_signed  (is_signed),
`endif
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sg;
    logic [7:0] eq;
    logic [7:0] er;
    logic       edz;
    logic       eov;
    int         elat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One operation: load on edge 0, optional start re-pulse mid-run, then result/hold checks.
  task automatic do_op(input vec_t v, input int repulse_at);
    int   lat;
    logic seq_ok;
    logic [7:0] hq;
    logic [7:0] hr;
    @(negedge clk);
    dividend = v.a;
    divisor  = v.b;
`ifdef DIV_SIGNED_EN
    is_signed = v.sg;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = ~v.a;
    divisor  = v.b + 8'd1;
    chk("busy_at_load", busy, 1'b1);
    chk("done_at_load", done, 1'b0);
    lat    = 0;
    seq_ok = 1'b1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (busy && done) seq_ok = 1'b0;
      if (!done && !busy) seq_ok = 1'b0;
      if (lat == repulse_at) begin
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'(v.elat));
    chk("busy_seq", seq_ok, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    chk("quotient", quotient, v.eq);
    chk("remainder", remainder, v.er);
    chk("div_by_zero", div_by_zero, v.edz);
    chk("ovf", ovf, v.eov);
    hq = quotient;
    hr = remainder;
    // A start presented during the DONE cycle must be ignored.
    if (v.elat > 1) begin
      dividend = 8'd9;
      divisor  = 8'd3;
      start    = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse_width", done, 1'b0);
    chk("busy_after_done", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("quotient_held", quotient, v.eq);
    chk("remainder_held", remainder, v.er);
    chk("dbz_held", div_by_zero, v.edz);
    chk("hold_copy", {hq, hr}, {v.eq, v.er});
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
`ifdef DIV_SIGNED_EN
    is_signed = 1'b0;
`endif

    //        a      b      sg    eq     er     edz   eov   lat
    vecs.push_back('{8'd200, 8'd7,   1'b0, 8'd28,  8'd4,   1'b0, 1'b0, 8});
    vecs.push_back('{8'd5,   8'd0,   1'b0, 8'hFF,  8'd5,   1'b1, 1'b0, 1});
    vecs.push_back('{8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   1'b0, 1'b0, 8});
    vecs.push_back('{8'd3,   8'd200, 1'b0, 8'd0,   8'd3,   1'b0, 1'b0, 8});
    vecs.push_back('{8'd0,   8'd5,   1'b0, 8'd0,   8'd0,   1'b0, 1'b0, 8});
    vecs.push_back('{8'd255, 8'd255, 1'b0, 8'd1,   8'd0,   1'b0, 1'b0, 8});
    vecs.push_back('{8'd254, 8'd255, 1'b0, 8'd0,   8'd254, 1'b0, 1'b0, 8});
    vecs.push_back('{8'd128, 8'd16,  1'b0, 8'd8,   8'd0,   1'b0, 1'b0, 8});
    vecs.push_back('{8'd0,   8'd0,   1'b0, 8'hFF,  8'd0,   1'b1, 1'b0, 1});
    vecs.push_back('{8'd100, 8'd3,   1'b0, 8'd33,  8'd1,   1'b0, 1'b0, 8});
`ifdef DIV_SIGNED_EN
    vecs.push_back('{8'hF9,  8'd2,   1'b1, 8'hFD,  8'hFF,  1'b0, 1'b0, 8});
    vecs.push_back('{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0, 1'b1, 8});
    vecs.push_back('{8'hF9,  8'd2,   1'b0, 8'd124, 8'd1,   1'b0, 1'b0, 8});
    vecs.push_back('{8'd7,   8'hFE,  1'b1, 8'hFD,  8'd1,   1'b0, 1'b0, 8});
    vecs.push_back('{8'hF9,  8'd0,   1'b1, 8'hFF,  8'hF9,  1'b1, 1'b0, 1});
`endif

    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q_r", {quotient, remainder}, 16'h0);
    chk("rst_flags", {div_by_zero, ovf}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) do_op(vecs[i], -1);

    // Start re-pulsed with 9/3 after edge 4 of a 200/7 run is ignored.
    v = '{8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0, 1'b0, 8};
    do_op(v, 4);

    // Asynchronous reset in the middle of an operation clears everything at once.
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_q_r", {quotient, remainder}, 16'h0);
    chk("midrst_flags", {div_by_zero, ovf}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{8'd100, 8'd10, 1'b0, 8'd10, 8'd0, 1'b0, 1'b0, 8};
    do_op(v, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
